// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780-style LCD bus: state encoding, bus
// constants and default timing, used by the reader and the write sequencer.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_E_HIGH,
        ST_E_LOW,
        ST_DONE
    } lcd_rd_state_e;

    localparam logic RS_CMD  = 1'b0;
    localparam logic RS_DATA = 1'b1;
    localparam logic RW_READ = 1'b1;
    localparam int   BF_BIT  = 7;

    localparam int T_AS_DEF      = 2;
    localparam int T_EH_DEF      = 12;
    localparam int T_EL_DEF      = 12;
    localparam int MAX_POLLS_DEF = 1000;

    localparam int TMR_W = 16;

    // Timer reload value for a phase lasting 'cycles' clocks.
    function automatic logic [TMR_W-1:0] tmr_reload(input int cycles);
        return TMR_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/lcd_bus_reader_if.sv
// Request/response and LCD bus signals of the read controller.
interface lcd_bus_reader_if;

    logic       req;
    logic       poll;
    logic       rs_sel;
    logic [7:0] db_in;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_e;
    logic       db_rd;
    logic       busy;
    logic       done;
    logic       bf;
    logic [6:0] ac;
    logic [7:0] rd_data;
    logic       timeout;

    modport master (
        output req, poll, rs_sel, db_in,
        input  lcd_rs, lcd_rw, lcd_e, db_rd, busy, done, bf, ac, rd_data, timeout
    );

    modport slave (
        input  req, poll, rs_sel, db_in,
        output lcd_rs, lcd_rw, lcd_e, db_rd, busy, done, bf, ac, rd_data, timeout
    );

endinterface

// File: rtl/lcd_bus_reader_cycle_timer.sv
// Loadable down-counter with zero flag; times each phase of an LCD read cycle.
module lcd_cycle_timer
    import lcd_pkg::*;
#(
    parameter int W = TMR_W
)(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         zero_o
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/lcd_bus_reader.sv
// Read-side LCD bus controller: BF/AC or data reads, optional busy-flag polling.
// Define LCD_RD_TIMEOUT_EN to bound polling by MAX_POLLS and report timeout.
module lcd_bus_reader
    import lcd_pkg::*;
#(
    parameter int          T_AS      = T_AS_DEF,
    parameter int          T_EH      = T_EH_DEF,
    parameter int          T_EL      = T_EL_DEF,
    parameter logic [15:0] MAX_POLLS = 16'(MAX_POLLS_DEF)
)(
    input  logic               clk,
    input  logic               rst_n,
    lcd_bus_reader_if.slave    bus
);

    if (T_AS < 1 || T_EH < 1 || T_EL < 1 || MAX_POLLS == 16'd0) begin : g_param_check
        $error("lcd_bus_reader: illegal timing parameter");
    end

    lcd_rd_state_e    state_q, state_d;
    logic             sel_q, sel_d;
    logic             poll_q, poll_d;
    logic             tmr_ld;
    logic [TMR_W-1:0] tmr_val;
    logic             tmr_zero;
    logic             sample;
    logic             active;

    logic             rs_q, rw_q, e_q, db_rd_q, busy_q, done_q, bf_q;
    logic [6:0]       ac_q;
    logic [7:0]       rd_data_q;

`ifdef LCD_RD_TIMEOUT_EN
    logic [15:0]      poll_cnt_q, poll_cnt_d;
    logic             timeout_q, timeout_d;
`endif

    lcd_cycle_timer #(.W(TMR_W)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_ld),
        .load_val_i (tmr_val),
        .zero_o     (tmr_zero)
    );

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        poll_d  = poll_q;
`ifdef LCD_RD_TIMEOUT_EN
        poll_cnt_d = poll_cnt_q;
        timeout_d  = timeout_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.req) begin
                    sel_d   = bus.poll ? RS_CMD : bus.rs_sel;
                    poll_d  = bus.poll;
`ifdef LCD_RD_TIMEOUT_EN
                    poll_cnt_d = '0;
                    timeout_d  = 1'b0;
`endif
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP:  if (tmr_zero) state_d = ST_E_HIGH;
            ST_E_HIGH: if (tmr_zero) state_d = ST_E_LOW;
            ST_E_LOW: begin
                if (tmr_zero) begin
`ifdef LCD_RD_TIMEOUT_EN
                    if (poll_q && bf_q && (poll_cnt_q < MAX_POLLS - 16'd1)) begin
                        poll_cnt_d = poll_cnt_q + 16'd1;
                        state_d    = ST_SETUP;
                    end else begin
                        timeout_d  = poll_q & bf_q;
                        state_d    = ST_DONE;
                    end
`else
                    state_d = (poll_q && bf_q) ? ST_SETUP : ST_DONE;
`endif
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        // Every phase entry (including a poll re-read) restarts the timer.
        tmr_ld  = (state_d != state_q);
        case (state_d)
            ST_SETUP:  tmr_val = tmr_reload(T_AS);
            ST_E_HIGH: tmr_val = tmr_reload(T_EH);
            ST_E_LOW:  tmr_val = tmr_reload(T_EL);
            default:   tmr_val = '0;
        endcase
    end

    assign active = (state_d == ST_SETUP) || (state_d == ST_E_HIGH) || (state_d == ST_E_LOW);
    assign sample = (state_q == ST_E_HIGH) && tmr_zero;

    // Bus outputs are decoded from the next state so they leave flops cleanly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            sel_q     <= RS_CMD;
            poll_q    <= 1'b0;
            rs_q      <= 1'b0;
            rw_q      <= 1'b0;
            e_q       <= 1'b0;
            db_rd_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bf_q      <= 1'b0;
            ac_q      <= '0;
            rd_data_q <= '0;
`ifdef LCD_RD_TIMEOUT_EN
            poll_cnt_q <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            poll_q  <= poll_d;
            rs_q    <= active ? sel_d : RS_CMD;
            rw_q    <= active ? RW_READ : ~RW_READ;
            e_q     <= (state_d == ST_E_HIGH);
            db_rd_q <= active;
            busy_q  <= (state_d != ST_IDLE);
            done_q  <= (state_d == ST_DONE);
            if (sample) begin
                rd_data_q <= bus.db_in;
                if (sel_q == RS_CMD) begin
                    bf_q <= bus.db_in[BF_BIT];
                    ac_q <= bus.db_in[6:0];
                end
            end
`ifdef LCD_RD_TIMEOUT_EN
            poll_cnt_q <= poll_cnt_d;
            timeout_q  <= timeout_d;
`endif
        end
    end

    assign bus.lcd_rs  = rs_q;
    assign bus.lcd_rw  = rw_q;
    assign bus.lcd_e   = e_q;
    assign bus.db_rd   = db_rd_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.bf      = bf_q;
    assign bus.ac      = ac_q;
    assign bus.rd_data = rd_data_q;
`ifdef LCD_RD_TIMEOUT_EN
    assign bus.timeout = timeout_q;
`else
    assign bus.timeout = 1'b0;
`endif

endmodule

// File: doc/lcd_bus_reader.md
# lcd_bus_reader

Read-side controller for the 8-bit HD44780-style character LCD bus. It owns the bus during LCD read cycles: it drives RS/RW/E, releases the writer's DB drivers, and samples DB. It returns either the busy flag plus address counter (RS=0), or one byte of DDRAM/CGRAM data (RS=1). The init/data write sequencer uses it to poll the busy flag between writes, instead of relying on fixed worst-case delays.

## Interface
Parameters:
- T_AS, 2: cycles RS/RW are stable before E rises (address setup); legal range ≥1.
- T_EH, 12: cycles E is held high; DB is sampled on the last one; legal range ≥1.
- T_EL, 12: cycles E is low after the pulse, with RW still 1 (hold / cycle time); legal range ≥1.
- MAX_POLLS, 1000: number of BF=1 reads in poll mode before timeout; 16-bit.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- req  in  1  start a transaction; sampled only in IDLE.
- poll  in  1  1 = repeat BF/AC reads until BF=0; sampled with req.
- rs_sel  in  1  0 = BF/AC read, 1 = data read; ignored (forced 0) when poll=1.
- db_in  in  8  LCD data bus, input side.
- lcd_rs  out  1  register select.
- lcd_rw  out  1  1 = read.
- lcd_e  out  1  enable strobe.
- db_rd  out  1  reader owns the bus; the writer must tristate DB while this is 1.
- busy  out  1  transaction in progress.
- done  out  1  one-cycle completion pulse.
- bf  out  1  last sampled DB[7] (for BF/AC reads).
- ac  out  7  last sampled DB[6:0] (for BF/AC reads).
- rd_data  out  8  last sampled DB (for data reads).
- timeout  out  1  last transaction ended by MAX_POLLS; valid with done.

## Operation
- States: IDLE, SETUP, E_HIGH, E_LOW, DONE.
- IDLE, req=1: latch poll and rs_sel, clear the poll counter, go to SETUP.
- SETUP: lcd_rw=1, db_rd=1, lcd_rs=latched sel, lcd_e=0; stay T_AS cycles, then go to E_HIGH.
- E_HIGH: lcd_e=1 for T_EH cycles.
  - On the final cycle, register db_in into rd_data.
  - For RS=0 reads, also register db_in into {bf, ac}.
  - Then go to E_LOW.
- E_LOW: lcd_e=0, lcd_rw=1 and db_rd=1 held for T_EL cycles, then evaluate:
  - poll=1, sampled BF=1, poll count < MAX_POLLS−1: increment the count and go to SETUP (back-to-back read, no IDLE gap).
  - Otherwise go to DONE.
- DONE: done=1 for one cycle; timeout=1 only if the poll limit was hit with BF still 1. Then lcd_rw=0, db_rd=0, and return to IDLE.
- busy=1 in every state except IDLE.
- req while busy is ignored (no queueing).
- rs_sel and poll changes after acceptance have no effect.
- Outputs are registered; lcd_e never glitches.
- lcd_rs/lcd_rw change only while lcd_e=0.
- bf/ac/rd_data hold their last values between transactions.
- Reset values: all outputs 0, state IDLE, counters 0.
- Reset mid-transaction: lcd_e, lcd_rw and db_rd drop to 0 asynchronously, and any partial sample is discarded.

## Timing
- A single read with req seen at cycle 0:
  - SETUP: cycles 1..T_AS.
  - E_HIGH: next T_EH cycles.
  - E_LOW: next T_EL cycles.
  - done: at cycle T_AS+T_EH+T_EL+1 (defaults: cycle 27).
- Each additional poll read adds exactly T_AS+T_EH+T_EL cycles.
- The sample is taken at the clk edge ending the last E_HIGH cycle. Sampled values become visible on bf/ac/rd_data in the first E_LOW cycle.
- A new req can be accepted in the cycle after done (IDLE); there is a 1-cycle minimum gap.
- MAX_POLLS=1 gives one read only; the timeout depends solely on the BF of that read.

## Configuration
- LCD_RD_TIMEOUT_EN defined: the poll counter is implemented and timeout is reported as above.
- LCD_RD_TIMEOUT_EN undefined: there is no poll counter. Poll mode repeats reads indefinitely until BF=0, timeout is tied to 0, and MAX_POLLS is unused.

## Structure
- Shared package lcd_pkg holds:
  - state encoding;
  - RS_CMD=0 / RS_DATA=1;
  - RW_READ=1;
  - BF_BIT=7;
  - the default timing constants, shared with the write sequencer.
- Sub-module lcd_cycle_timer: a loadable down-counter with a zero flag. It is reloaded on each state entry with T_AS/T_EH/T_EL. One instance is used.

## Test plan
- Single BF/AC read, db_in=8'h05 during E_HIGH → done at cycle 27, bf=0, ac=7'h05, rs=0, e high for exactly 12 cycles.
- Data read, rs_sel=1, db_in=8'h41 → rd_data=8'h41, bf/ac unchanged, lcd_rs=1 throughout SETUP..E_LOW.
- Poll mode with db_in[7]=1 for 3 reads then 8'h12 → 4 E pulses, done at cycle 4·26+1=105, bf=0, ac=7'h12, timeout=0.
- Timeout with MAX_POLLS=4 and db_in=8'h80 constant → 4 pulses then done with timeout=1, bf=1. With the macro undefined, pulses continue beyond 4 and done never fires.
- req held high across a transaction → a second transaction starts the cycle after done. req pulses while busy produce no extra transaction.
- rst_n asserted in E_HIGH → lcd_e, lcd_rw and db_rd are 0 before the next clk edge, state is IDLE, and no done pulse occurs.
